// File: rtl/thresh_pkg.sv
// -----------------------------------------------------------------------------
// thresh_pkg
// Shared types for the hysteresis threshold stage.
//   cls_t      : 2-bit pixel class (none / weak / strong)
//   state_t    : frame sequencing states (IDLE, RUN, FLUSH)
// -----------------------------------------------------------------------------
package thresh_pkg;

    typedef logic [1:0] cls_t;

    localparam cls_t CLS_NONE   = 2'd0;
    localparam cls_t CLS_WEAK   = 2'd1;
    localparam cls_t CLS_STRONG = 2'd2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2
    } state_t;

    function automatic logic is_strong(input cls_t c);
        return c == CLS_STRONG;
    endfunction

endpackage

// File: rtl/class_line_buffer.sv
// -----------------------------------------------------------------------------
// class_line_buffer
// Depth-DEPTH shift line of 2-bit pixel classes. One entry moves per enabled
// cycle, so dout is the class written DEPTH shifts earlier (same column, one
// line up).
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset (clears contents)
//   en         : shift enable
//   din        : class entering the line
//   dout       : class leaving the line
// -----------------------------------------------------------------------------
module class_line_buffer
    import thresh_pkg::*;
#(
    parameter int DEPTH = 640
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    input  cls_t din,
    output cls_t dout
);

    cls_t mem [DEPTH];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= CLS_NONE;
        end else if (en) begin
            mem[0] <= din;
            for (int i = 1; i < DEPTH; i++) mem[i] <= mem[i-1];
        end
    end

    assign dout = mem[DEPTH-1];

endmodule

// File: rtl/hysteresis_threshold.sv
// -----------------------------------------------------------------------------
// hysteresis_threshold
// Streaming double-threshold classifier with single-pass hysteresis. Each pixel
// is classified none/weak/strong; a weak pixel becomes an edge when any of its
// 8 neighbours is strong. Output order and count match the input frame.
// Optional build macro: THRESH_STATS_EN (adds per-frame class statistics).
// Ports:
//   clk, rst_n            : clock, asynchronous active-low reset
//   low_thr, high_thr     : thresholds, captured with the accepted sof pixel
//   in_valid/in_ready     : input handshake; in_pix gradient, in_sof frame start
//   out_valid/out_ready   : output handshake
//   out_pix               : all-ones for edge, zero otherwise
//   out_class             : pre-hysteresis class of the pixel
//   out_sof, out_eof      : first / last pixel of the output frame
//   busy                  : frame in progress or draining
//   stat_strong/weak/promoted (THRESH_STATS_EN only): counts of last frame
// -----------------------------------------------------------------------------
module hysteresis_threshold
    import thresh_pkg::*;
#(
    parameter int PIX_W    = 8,
    parameter int IMG_W    = 640,
    parameter int IMG_H    = 480,
    parameter int LOW_DEF  = 40,
    parameter int HIGH_DEF = 120,
    parameter int CNT_W    = 20
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [PIX_W-1:0] low_thr,
    input  logic [PIX_W-1:0] high_thr,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [PIX_W-1:0] in_pix,
    input  logic             in_sof,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [PIX_W-1:0] out_pix,
    output cls_t             out_class,
    output logic             out_sof,
    output logic             out_eof,
    output logic             busy
`ifdef THRESH_STATS_EN
    ,
    output logic [CNT_W-1:0] stat_strong,
    output logic [CNT_W-1:0] stat_weak,
    output logic [CNT_W-1:0] stat_promoted
`endif
);

    localparam int COL_W  = $clog2(IMG_W + 1);
    localparam int ROW_W  = (IMG_H > 2) ? $clog2(IMG_H) : 1;
    localparam int FILL_W = $clog2(IMG_W + 2);

    generate
        if (IMG_W < 3 || IMG_H < 2 || CNT_W < 1) begin : g_bad_cfg
            $error("hysteresis_threshold: unsupported geometry or counter width");
        end
    endgenerate

    state_t             state;
    logic               live;       // low during reset and the cycle after
    logic [PIX_W-1:0]   low_q, high_q;
    logic [COL_W-1:0]   in_col, flush_cnt, cen_col;
    logic [ROW_W-1:0]   in_row, cen_row;
    logic [FILL_W-1:0]  fill_cnt;
    cls_t               win_a [3];  // column just left of the incoming one (centre column)
    cls_t               win_b [3];  // left column
    cls_t               col_new [3];
    cls_t               lb1_out, lb2_out, new_cls, centre;
    logic               stall, sof_take, run_take, inject, shift, produce;
    logic               m_top, m_bot, m_left, m_right, nb_strong, edge_now;
    logic [PIX_W-1:0]   lo_sel, hi_sel;

    function automatic cls_t classify(input logic [PIX_W-1:0] pix,
                                      input logic [PIX_W-1:0] lo,
                                      input logic [PIX_W-1:0] hi);
        logic [PIX_W-1:0] lo_eff;
        // An inverted pair collapses the weak band to nothing.
        lo_eff = (lo > hi) ? hi : lo;
        if (pix >= hi)          return CLS_STRONG;
        else if (pix >= lo_eff) return CLS_WEAK;
        else                    return CLS_NONE;
    endfunction

    // ---------------- handshake / shift control ----------------
    assign stall    = out_valid && !out_ready;
    assign sof_take = live && (state == IDLE) && in_valid && in_sof;
    assign run_take = (state == RUN) && in_valid && !stall;
    assign inject   = (state == FLUSH) && !stall;
    assign shift    = sof_take || run_take || inject;
    // The sof shift never produces: it restarts the fill for a new frame.
    assign produce  = (run_take || inject) && (fill_cnt == FILL_W'(IMG_W + 1));
    assign in_ready = live && ((state == IDLE) || ((state == RUN) && !stall));
    assign busy     = (state != IDLE);

    // The sof pixel itself is classified with the thresholds arriving with it.
    assign lo_sel  = sof_take ? low_thr  : low_q;
    assign hi_sel  = sof_take ? high_thr : high_q;
    assign new_cls = inject ? CLS_NONE : classify(in_pix, lo_sel, hi_sel);

    class_line_buffer #(.DEPTH(IMG_W)) u_lb1 (
        .clk(clk), .rst_n(rst_n), .en(shift), .din(new_cls), .dout(lb1_out)
    );
    class_line_buffer #(.DEPTH(IMG_W)) u_lb2 (
        .clk(clk), .rst_n(rst_n), .en(shift), .din(lb1_out), .dout(lb2_out)
    );

    // ---------------- neighbourhood decision ----------------
    // Incoming column: two lines up, one line up, current line.
    assign col_new[0] = lb2_out;
    assign col_new[1] = lb1_out;
    assign col_new[2] = new_cls;
    assign centre     = win_a[1];

    // Masks follow the centre position, so stale line-buffer data on row 0
    // and line-to-line wrap at the frame sides never reach the decision.
    assign m_top   = (cen_row == '0);
    assign m_bot   = (cen_row == ROW_W'(IMG_H - 1));
    assign m_left  = (cen_col == '0);
    assign m_right = (cen_col == COL_W'(IMG_W - 1));

    always_comb begin
        nb_strong = 1'b0;
        for (int r = 0; r < 3; r++) begin
            if (!((r == 0 && m_top) || (r == 2 && m_bot))) begin
                if (!m_left && is_strong(win_b[r]))    nb_strong = 1'b1;
                if (r != 1 && is_strong(win_a[r]))     nb_strong = 1'b1;
                if (!m_right && is_strong(col_new[r])) nb_strong = 1'b1;
            end
        end
    end

    assign edge_now = is_strong(centre) || ((centre == CLS_WEAK) && nb_strong);

    // ---------------- frame FSM ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            live      <= 1'b0;
            low_q     <= PIX_W'(LOW_DEF);
            high_q    <= PIX_W'(HIGH_DEF);
            in_col    <= '0;
            in_row    <= '0;
            flush_cnt <= '0;
        end else begin
            live <= 1'b1;
            case (state)
                IDLE: begin
                    if (sof_take) begin
                        state  <= RUN;
                        low_q  <= low_thr;
                        high_q <= high_thr;
                        in_col <= COL_W'(1);
                        in_row <= '0;
                    end
                end
                RUN: begin
                    if (run_take) begin
                        if (in_col == COL_W'(IMG_W - 1)) begin
                            in_col <= '0;
                            if (in_row == ROW_W'(IMG_H - 1)) begin
                                state     <= FLUSH;
                                flush_cnt <= '0;
                            end else begin
                                in_row <= in_row + 1'b1;
                            end
                        end else begin
                            in_col <= in_col + 1'b1;
                        end
                    end
                end
                FLUSH: begin
                    if (inject) begin
                        if (flush_cnt == COL_W'(IMG_W)) state <= IDLE;
                        else flush_cnt <= flush_cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // ---------------- window and centre tracking ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int r = 0; r < 3; r++) begin
                win_a[r] <= CLS_NONE;
                win_b[r] <= CLS_NONE;
            end
            fill_cnt <= '0;
            cen_col  <= '0;
            cen_row  <= '0;
        end else if (shift) begin
            for (int r = 0; r < 3; r++) begin
                win_b[r] <= win_a[r];
                win_a[r] <= col_new[r];
            end
            if (sof_take) begin
                fill_cnt <= FILL_W'(1);
                cen_col  <= '0;
                cen_row  <= '0;
            end else if (produce) begin
                if (m_right) begin
                    cen_col <= '0;
                    cen_row <= cen_row + 1'b1;
                end else begin
                    cen_col <= cen_col + 1'b1;
                end
            end else begin
                fill_cnt <= fill_cnt + 1'b1;
            end
        end
    end

    // ---------------- output register ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_pix   <= '0;
            out_class <= CLS_NONE;
            out_sof   <= 1'b0;
            out_eof   <= 1'b0;
        end else if (!stall) begin
            out_valid <= produce;
            if (produce) begin
                out_pix   <= {PIX_W{edge_now}};
                out_class <= centre;
                out_sof   <= m_top && m_left;
                out_eof   <= m_bot && m_right;
            end
        end
    end

`ifdef THRESH_STATS_EN
    logic [CNT_W-1:0] cnt_strong, cnt_weak, cnt_prom;
    logic             first_px, hit_s, hit_w, hit_p;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v,
                                                 input logic hit);
        if (hit && (v != '1)) return v + CNT_W'(1);
        return v;
    endfunction

    assign first_px = m_top && m_left;
    assign hit_s    = is_strong(centre);
    assign hit_w    = (centre == CLS_WEAK);
    assign hit_p    = hit_w && nb_strong;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_strong    <= '0;
            cnt_weak      <= '0;
            cnt_prom      <= '0;
            stat_strong   <= '0;
            stat_weak     <= '0;
            stat_promoted <= '0;
        end else begin
            if (produce) begin
                // First pixel of a frame restarts the counts.
                cnt_strong <= first_px ? CNT_W'(hit_s) : sat_inc(cnt_strong, hit_s);
                cnt_weak   <= first_px ? CNT_W'(hit_w) : sat_inc(cnt_weak, hit_w);
                cnt_prom   <= first_px ? CNT_W'(hit_p) : sat_inc(cnt_prom, hit_p);
            end
            if (out_valid && out_ready && out_eof) begin
                stat_strong   <= cnt_strong;
                stat_weak     <= cnt_weak;
                stat_promoted <= cnt_prom;
            end
        end
    end
`endif

endmodule

// File: tb/tb_hysteresis_threshold.sv
module tb_hysteresis_threshold;

    import thresh_pkg::*;

    localparam int W = 4;
    localparam int H = 3;
    localparam int N = W * H;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] low_thr = 8'd40, high_thr = 8'd120;
    logic       in_valid = 1'b0, in_sof = 1'b0;
    logic [7:0] in_pix = 8'd0;
    logic       in_ready;
    logic       out_valid, out_sof, out_eof, busy;
    logic       out_ready = 1'b1;
    logic [7:0] out_pix;
    cls_t       out_class;
`ifdef THRESH_STATS_EN
    logic [19:0] stat_strong, stat_weak, stat_promoted;
`endif

    hysteresis_threshold #(
        .PIX_W(8), .IMG_W(W), .IMG_H(H), .LOW_DEF(40), .HIGH_DEF(120), .CNT_W(20)
    ) dut (
        .clk(clk), .rst_n(rst_n), .low_thr(low_thr), .high_thr(high_thr),
        .in_valid(in_valid), .in_ready(in_ready), .in_pix(in_pix), .in_sof(in_sof),
        .out_valid(out_valid), .out_ready(out_ready), .out_pix(out_pix),
        .out_class(out_class), .out_sof(out_sof), .out_eof(out_eof), .busy(busy)
`ifdef THRESH_STATS_EN
        , .stat_strong(stat_strong), .stat_weak(stat_weak), .stat_promoted(stat_promoted)
`endif
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input int got, input int exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    // out_ready pattern 1,0,0,1 when rdy_mode is set
    int cyc = 0;
    bit rdy_mode = 1'b0;
    always @(posedge clk) begin
        cyc++;
        #1 out_ready = rdy_mode ? ((cyc % 4 == 0) || (cyc % 4 == 3)) : 1'b1;
    end

    int q_pix[$], q_cls[$], q_sof[$], q_eof[$];
    bit hold_prev = 1'b0;
    int hold_pix, hold_cls;

    always @(negedge clk) begin
        if (!rst_n) begin
            hold_prev = 1'b0;
        end else begin
            if (hold_prev && out_valid) begin
                check("hold_pix", out_pix, hold_pix);
                check("hold_cls", out_class, hold_cls);
            end
            if (out_valid && out_ready) begin
                q_pix.push_back(out_pix);
                q_cls.push_back(out_class);
                q_sof.push_back(out_sof);
                q_eof.push_back(out_eof);
            end
            hold_prev = out_valid && !out_ready;
            hold_pix  = out_pix;
            hold_cls  = out_class;
        end
    end

    int fp[N];   // frame pixels, raster order
    int ec[N];   // expected class
    int ee[N];   // expected edge flag

    task automatic send_pix(input int p, input bit sof, input int lo, input int hi);
        int g;
        @(negedge clk);
        in_valid = 1'b1; in_pix = 8'(p); in_sof = sof;
        low_thr = 8'(lo); high_thr = 8'(hi);
        g = 0;
        while (!in_ready && g < 200) begin
            @(negedge clk);
            g++;
        end
        if (g >= 200) check("in_ready_wait", 0, 1);
    endtask

    // Non-sof pixels carry thresholds 0/1 so a missed capture is visible.
    task automatic send_frame(input int lo, input int hi);
        for (int i = 0; i < N; i++)
            send_pix(fp[i], i == 0, (i == 0) ? lo : 0, (i == 0) ? hi : 1);
        @(negedge clk);
        in_valid = 1'b0; in_sof = 1'b0;
        check("busy_after_last", busy, 1);
    endtask

    task automatic clear_q();
        q_pix.delete(); q_cls.delete(); q_sof.delete(); q_eof.delete();
    endtask

    task automatic check_frame(input string tag);
        int g;
        g = 0;
        while ((q_pix.size() < N || busy) && g < 500) begin
            @(negedge clk);
            g++;
        end
        repeat (8) @(negedge clk);
        check($sformatf("%s_count", tag), q_pix.size(), N);
        for (int i = 0; i < N && i < q_pix.size(); i++) begin
            check($sformatf("%s_cls%0d", tag, i), q_cls[i], ec[i]);
            check($sformatf("%s_pix%0d", tag, i), q_pix[i], ee[i] ? 255 : 0);
            check($sformatf("%s_sof%0d", tag, i), q_sof[i], (i == 0) ? 1 : 0);
            check($sformatf("%s_eof%0d", tag, i), q_eof[i], (i == N - 1) ? 1 : 0);
        end
        clear_q();
    endtask

    task automatic zero_frame();
        for (int i = 0; i < N; i++) begin
            fp[i] = 0; ec[i] = 0; ee[i] = 0;
        end
    endtask

    initial begin
        // reset state
        repeat (2) @(negedge clk);
        check("rst_in_ready", in_ready, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_pix", out_pix, 0);
        check("rst_out_class", out_class, 0);
        check("rst_out_sof", out_sof, 0);
        check("rst_out_eof", out_eof, 0);
        check("rst_busy", busy, 0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        check("idle_in_ready", in_ready, 1);

        // all strong
        for (int i = 0; i < N; i++) begin
            fp[i] = 200; ec[i] = 2; ee[i] = 1;
        end
        send_frame(40, 120);
        check_frame("all200");

        // pixels without sof are dropped in IDLE
        for (int i = 0; i < 3; i++) send_pix(200, 1'b0, 40, 120);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (3) @(negedge clk);
        check("drop_busy", busy, 0);
        check("drop_outputs", q_pix.size(), 0);

        // weak centre promoted by diagonal strong neighbour
        zero_frame();
        fp[0] = 130; ec[0] = 2; ee[0] = 1;
        fp[5] = 60;  ec[5] = 1; ee[5] = 1;
        send_frame(40, 120);
        check_frame("diag");

        // no wrap from line end to next line start
        zero_frame();
        fp[7] = 60;  ec[7] = 1; ee[7] = 0;
        fp[8] = 130; ec[8] = 2; ee[8] = 1;
        send_frame(40, 120);
        check_frame("nowrap");

        // inverted thresholds: low collapses onto high (50)
        zero_frame();
        fp[0] = 70; ec[0] = 2; ee[0] = 1;
        fp[1] = 50; ec[1] = 2; ee[1] = 1;
        fp[2] = 49; ec[2] = 0; ee[2] = 0;
        send_frame(100, 50);
        check_frame("invthr");

        // backpressure 1-0-0-1 through RUN and FLUSH
        zero_frame();
        fp[0] = 130; ec[0] = 2; ee[0] = 1;
        fp[5] = 60;  ec[5] = 1; ee[5] = 1;
        rdy_mode = 1'b1;
        send_frame(40, 120);
        check_frame("stall");
        rdy_mode = 1'b0;
        repeat (3) @(negedge clk);

        // reset mid-frame
        for (int i = 0; i < 5; i++) send_pix(200, i == 0, 40, 120);
        @(negedge clk);
        in_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        check("midrst_busy", busy, 0);
        check("midrst_out_valid", out_valid, 0);
        check("midrst_in_ready", in_ready, 0);
        @(negedge clk);
        rst_n = 1'b1;
        clear_q();
        repeat (2) @(negedge clk);
        zero_frame();
        fp[7] = 60;  ec[7] = 1; ee[7] = 0;
        fp[8] = 130; ec[8] = 2; ee[8] = 1;
        send_frame(40, 120);
        check_frame("after_rst");

`ifdef THRESH_STATS_EN
        // 6 strong, 2 promoted weak, 1 isolated weak
        zero_frame();
        for (int r = 0; r < H; r++) begin
            fp[r*W+0] = 200; ec[r*W+0] = 2; ee[r*W+0] = 1;
            fp[r*W+1] = 200; ec[r*W+1] = 2; ee[r*W+1] = 1;
        end
        fp[2]  = 60; ec[2]  = 1; ee[2]  = 1;
        fp[6]  = 60; ec[6]  = 1; ee[6]  = 1;
        fp[11] = 60; ec[11] = 1; ee[11] = 0;
        send_frame(40, 120);
        check_frame("stats");
        check("stat_strong", stat_strong, 6);
        check("stat_weak", stat_weak, 3);
        check("stat_promoted", stat_promoted, 2);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

endmodule
